// File: rtl/imm_split.sv
// ----------------------------------------------------------------------------
// imm_split
//   Splits a 32-bit word into the 15-bit immediate beat(s) that the 15->32
//   sign-extend path needs to rebuild it. A word whose bits [31:14] are all
//   equal goes out as a single SHORT beat (the consumer sign-extends it).
//   Any other word goes out as three zero-extended beats: TOP (bits 31:30),
//   MID (bits 29:15) and LOW (bits 14:0).
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   in_valid   in   in_data is valid
//   in_ready   out  word can be accepted (high only when idle)
//   in_data    in   [IN_W-1:0]  word to encode
//   out_valid  out  current beat is valid
//   out_ready  in   downstream accepts the current beat
//   out_imm    out  [IMM_W-1:0] immediate field of the current beat
//   out_kind   out  [1:0] 00 SHORT, 01 TOP, 10 MID, 11 LOW
//   out_last   out  current beat is the final one for this word
// ----------------------------------------------------------------------------
module imm_split #(
    parameter int IN_W  = 32,
    parameter int IMM_W = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IMM_W-1:0] out_imm,
    output logic [1:0]       out_kind,
    output logic             out_last
);

    localparam logic [1:0] KIND_SHORT = 2'b00;
    localparam logic [1:0] KIND_TOP   = 2'b01;
    localparam logic [1:0] KIND_MID   = 2'b10;
    localparam logic [1:0] KIND_LOW   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHORT,
        ST_TOP,
        ST_MID,
        ST_LOW
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [IN_W-1:0]    r_word;
    logic [IN_W-1:0]    w_word_next;
    logic [IMM_W-1:0]   r_imm;
    logic [IMM_W-1:0]   w_imm_next;
    logic [1:0]         r_kind;
    logic [1:0]         w_kind_next;
    logic               r_last;
    logic               w_last_next;
    logic               w_fits;

    // Word fits a signed IMM_W-bit immediate when every bit from the
    // immediate's sign bit upward is identical.
    assign w_fits = (&in_data[IN_W-1:IMM_W-1]) | ~(|in_data[IN_W-1:IMM_W-1]);

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state != ST_IDLE);
    assign out_imm   = r_imm;
    assign out_kind  = r_kind;
    assign out_last  = r_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Beat contents are computed one state ahead so that the registered
    // outputs are already correct on the edge that enters each state.
    always_comb begin
        w_state_next = r_state;
        w_word_next  = r_word;
        w_imm_next   = r_imm;
        w_kind_next  = r_kind;
        w_last_next  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_word_next = in_data;
                    if (w_fits) begin
                        w_state_next = ST_SHORT;
                        w_imm_next   = in_data[IMM_W-1:0];
                        w_kind_next  = KIND_SHORT;
                        w_last_next  = 1'b1;
                    end else begin
                        w_state_next = ST_TOP;
                        w_imm_next   = {{(IMM_W-2){1'b0}}, in_data[IN_W-1:IN_W-2]};
                        w_kind_next  = KIND_TOP;
                        w_last_next  = 1'b0;
                    end
                end
            end
            ST_TOP: begin
                if (out_ready) begin
                    w_state_next = ST_MID;
                    w_imm_next   = r_word[2*IMM_W-1:IMM_W];
                    w_kind_next  = KIND_MID;
                    w_last_next  = 1'b0;
                end
            end
            ST_MID: begin
                if (out_ready) begin
                    w_state_next = ST_LOW;
                    w_imm_next   = r_word[IMM_W-1:0];
                    w_kind_next  = KIND_LOW;
                    w_last_next  = 1'b1;
                end
            end
            ST_SHORT, ST_LOW: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                    w_imm_next   = '0;
                    w_kind_next  = KIND_SHORT;
                    w_last_next  = 1'b0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word <= '0;
            r_imm  <= '0;
            r_kind <= KIND_SHORT;
            r_last <= 1'b0;
        end else begin
            r_word <= w_word_next;
            r_imm  <= w_imm_next;
            r_kind <= w_kind_next;
            r_last <= w_last_next;
        end
    end

endmodule

// File: tb/tb_imm_split.sv
`timescale 1ns/1ps
module tb_imm_split;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] out_imm;
    logic [1:0]  out_kind;
    logic        out_last;

    int unsigned checks;
    int unsigned errors;

    imm_split #(.IN_W(32), .IMM_W(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_kind  (out_kind),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] din;
        int unsigned nb;
        logic [14:0] i0;
        logic [14:0] i1;
        logic [14:0] i2;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic [14:0] imm,
                              input logic [1:0] kind, input logic last);
        chk({tag, " out_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, " in_ready"},  {31'b0, in_ready},  32'd0);
        chk({tag, " imm"},       {17'b0, out_imm},   {17'b0, imm});
        chk({tag, " kind"},      {30'b0, out_kind},  {30'b0, kind});
        chk({tag, " last"},      {31'b0, out_last},  {31'b0, last});
    endtask

    // Presents a word and returns #1 after the accepting edge.
    task automatic send_word(input logic [31:0] d);
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("in_ready wait timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [14:0] imms[3];
        logic [1:0]  kinds[3];
        logic [14:0] beat_imm[$];
        logic [1:0]  beat_kind[$];
        logic [31:0] word;
        logic [31:0] rebuilt;
        logic        done;

        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        vecs[0] = '{32'h0000_0055, 1, 15'h0055, 15'h0, 15'h0};
        vecs[1] = '{32'hFFFF_FFAA, 1, 15'h7FAA, 15'h0, 15'h0};
        vecs[2] = '{32'hFFFF_C000, 1, 15'h4000, 15'h0, 15'h0};
        vecs[3] = '{32'h0000_3FFF, 1, 15'h3FFF, 15'h0, 15'h0};
        vecs[4] = '{32'hFFFF_FFFF, 1, 15'h7FFF, 15'h0, 15'h0};
        vecs[5] = '{32'h0000_4000, 3, 15'h0000, 15'h0000, 15'h4000};
        vecs[6] = '{32'hFFFF_BFFF, 3, 15'h0003, 15'h7FFF, 15'h3FFF};
        vecs[7] = '{32'h1234_5678, 3, 15'h0000, 15'h2468, 15'h5678};
        vecs[8] = '{32'h8000_0000, 3, 15'h0002, 15'h0000, 15'h0000};
        vecs[9] = '{32'h7FFF_FFFF, 3, 15'h0001, 15'h7FFF, 15'h7FFF};

        #12;
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset out_imm",   {17'b0, out_imm},   32'd0);
        chk("reset out_kind",  {30'b0, out_kind},  32'd0);
        chk("reset out_last",  {31'b0, out_last},  32'd0);
        chk("reset in_ready",  {31'b0, in_ready},  32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors with out_ready held high.
        for (int v = 0; v < 10; v++) begin
            imms[0] = vecs[v].i0;
            imms[1] = vecs[v].i1;
            imms[2] = vecs[v].i2;
            if (vecs[v].nb == 1) begin
                kinds[0] = 2'b00;
            end else begin
                kinds[0] = 2'b01;
                kinds[1] = 2'b10;
                kinds[2] = 2'b11;
            end
            send_word(vecs[v].din);
            for (int unsigned b = 0; b < vecs[v].nb; b++) begin
                check_beat($sformatf("vec%0d beat%0d", v, b), imms[b], kinds[b],
                           b == vecs[v].nb - 1);
                step();
            end
            chk($sformatf("vec%0d idle in_ready", v), {31'b0, in_ready}, 32'd1);
            chk($sformatf("vec%0d idle out_valid", v), {31'b0, out_valid}, 32'd0);
        end

        // Backpressure during MID, with a competing word offered while busy.
        send_word(32'h1234_5678);
        check_beat("bp top", 15'h0000, 2'b01, 1'b0);
        step();
        check_beat("bp mid", 15'h2468, 2'b10, 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0000_0007;
        for (int c = 0; c < 3; c++) begin
            step();
            check_beat($sformatf("bp hold%0d", c), 15'h2468, 2'b10, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check_beat("bp low", 15'h5678, 2'b11, 1'b1);
        step();
        chk("bp idle in_ready", {31'b0, in_ready}, 32'd1);

        // Reset asserted in MID: out_valid must fall without a clock edge.
        send_word(32'h1234_5678);
        step();
        check_beat("rst mid", 15'h2468, 2'b10, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst async out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst async in_ready",  {31'b0, in_ready},  32'd1);
        @(negedge clk);
        rst = 1'b0;
        chk("rst release in_ready", {31'b0, in_ready}, 32'd1);
        send_word(32'h0000_0001);
        check_beat("post rst short", 15'h0001, 2'b00, 1'b1);
        step();
        chk("post rst idle", {31'b0, in_ready}, 32'd1);

        // Random words with random backpressure; rebuild from beats.
        for (int r = 0; r < 40; r++) begin
            word = $urandom;
            if (r % 3 == 0) begin
                word = {{17{word[14]}}, word[14:0]};
            end
            out_ready = 1'b1;
            send_word(word);
            beat_imm.delete();
            beat_kind.delete();
            done = 1'b0;
            for (int c = 0; c < 60 && !done; c++) begin
                out_ready = ($urandom_range(0, 1) == 1);
                if (out_valid && out_ready) begin
                    beat_imm.push_back(out_imm);
                    beat_kind.push_back(out_kind);
                    done = out_last;
                end
                step();
            end
            out_ready = 1'b1;
            if (!done) begin
                chk($sformatf("rand%0d timeout", r), 32'd0, 32'd1);
            end else begin
                if (beat_imm.size() == 1 && beat_kind[0] == 2'b00) begin
                    rebuilt = {{17{beat_imm[0][14]}}, beat_imm[0]};
                end else if (beat_imm.size() == 3 && beat_kind[0] == 2'b01 &&
                             beat_kind[1] == 2'b10 && beat_kind[2] == 2'b11) begin
                    rebuilt = ({17'b0, beat_imm[0]} << 30) |
                              ({17'b0, beat_imm[1]} << 15) |
                              {17'b0, beat_imm[2]};
                end else begin
                    rebuilt = ~word;
                end
                chk($sformatf("rand%0d rebuild", r), rebuilt, word);
                chk($sformatf("rand%0d beats", r), beat_imm.size(),
                    (word[31:14] == '0 || word[31:14] == '1) ? 32'd1 : 32'd3);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
